// File: rtl/sha256_host_ctrl.sv
// Host-side controller for the SHA-256 engine's shared word memory.
// Streams a message into memory, kicks the engine, waits for completion,
// then reads the 8-word digest back out as a valid/ready stream.
module sha256_host_ctrl #(
   parameter int unsigned NUM_OF_WORDS = 20
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] message_addr,
   input  logic [15:0] output_addr,
   input  logic        msg_valid,
   input  logic [31:0] msg_data,
   output logic        msg_ready,
   output logic        mem_grant_host,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [31:0] mem_write_data,
   input  logic [31:0] mem_read_data,
   output logic        sha_start,
   input  logic        sha_done,
   output logic        digest_valid,
   output logic [31:0] digest_data,
   output logic        digest_last,
   input  logic        digest_ready,
   output logic        busy,
   output logic        error
);

   typedef enum logic [2:0] {
      S_LOAD,
      S_KICK,
      S_WAIT_LOW,
      S_WAIT_HIGH,
      S_RD_ADDR,
      S_RD_DATA,
      S_OUT
   } state_t;

   localparam logic [5:0] LAST_WC = 6'(NUM_OF_WORDS - 1);

   state_t      state_q;
   logic [5:0]  wc_q;
   logic [2:0]  dc_q;
   logic [1:0]  tmo_q;
   logic        grant_q;
   logic        we_q;
   logic [15:0] addr_q;
   logic [31:0] wdata_q;
   logic        start_q;
   logic        dvalid_q;
   logic [31:0] ddata_q;
   logic        dlast_q;
   logic        busy_q;
   logic        error_q;

   logic [15:0] wr_addr_d;
   logic [15:0] rd_next_d;

   // Address arithmetic wraps modulo 2^16 by construction of the 16-bit sums.
   always_comb begin
      wr_addr_d = message_addr + {10'd0, wc_q};
      rd_next_d = output_addr + {13'd0, dc_q} + 16'd1;
   end

   assign msg_ready      = (state_q == S_LOAD) && !reset;
   assign mem_grant_host = grant_q;
   assign mem_we         = we_q;
   assign mem_addr       = addr_q;
   assign mem_write_data = wdata_q;
   assign sha_start      = start_q;
   assign digest_valid   = dvalid_q;
   assign digest_data    = ddata_q;
   assign digest_last    = dlast_q;
   assign busy           = busy_q;
   assign error          = error_q;

   // Control FSM with all outputs registered alongside the state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_LOAD;
         wc_q     <= '0;
         dc_q     <= '0;
         tmo_q    <= '0;
         grant_q  <= 1'b1;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         start_q  <= 1'b0;
         dvalid_q <= 1'b0;
         ddata_q  <= '0;
         dlast_q  <= 1'b0;
         busy_q   <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         case (state_q)
            S_LOAD: begin
               if (msg_valid) begin
                  we_q    <= 1'b1;
                  addr_q  <= wr_addr_d;
                  wdata_q <= msg_data;
                  wc_q    <= wc_q + 6'd1;
                  error_q <= 1'b0;
                  busy_q  <= 1'b1;
                  if (wc_q == LAST_WC) state_q <= S_KICK;
               end else begin
                  we_q <= 1'b0;
               end
            end
            S_KICK: begin
               we_q    <= 1'b0;
               grant_q <= 1'b0;
               start_q <= 1'b1;
               tmo_q   <= '0;
               state_q <= S_WAIT_LOW;
            end
            // A done level still high from before the start is not completion;
            // only a low-then-high sequence counts.
            S_WAIT_LOW: begin
               start_q <= 1'b0;
               if (!sha_done) begin
                  state_q <= S_WAIT_HIGH;
               end else if (tmo_q == 2'd3) begin
                  error_q <= 1'b1;
                  grant_q <= 1'b1;
                  wc_q    <= '0;
                  busy_q  <= 1'b0;
                  state_q <= S_LOAD;
               end else begin
                  tmo_q <= tmo_q + 2'd1;
               end
            end
            // Read address is registered on entry to RD_ADDR so the memory
            // sees it during RD_ADDR and returns data during RD_DATA.
            S_WAIT_HIGH: begin
               if (sha_done) begin
                  grant_q <= 1'b1;
                  dc_q    <= '0;
                  addr_q  <= output_addr;
                  state_q <= S_RD_ADDR;
               end
            end
            S_RD_ADDR: begin
               we_q    <= 1'b0;
               state_q <= S_RD_DATA;
            end
            S_RD_DATA: begin
               ddata_q  <= mem_read_data;
               dvalid_q <= 1'b1;
               dlast_q  <= (dc_q == 3'd7);
               state_q  <= S_OUT;
            end
            S_OUT: begin
               if (digest_ready) begin
                  dvalid_q <= 1'b0;
                  dlast_q  <= 1'b0;
                  if (dc_q == 3'd7) begin
                     wc_q    <= '0;
                     dc_q    <= '0;
                     busy_q  <= 1'b0;
                     state_q <= S_LOAD;
                  end else begin
                     dc_q    <= dc_q + 3'd1;
                     addr_q  <= rd_next_d;
                     state_q <= S_RD_ADDR;
                  end
               end
            end
            default: state_q <= S_LOAD;
         endcase
      end
   end

endmodule
